// File: rtl/exec_pkg.sv
// Shared types and field positions for the exec_sequencer execute stage.
// Pulled in with import exec_pkg::*; holds the FSM state type and the instruction decoder.
package exec_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_WB,
        S_WB_IMM,
        S_FIN
    } state_t;

    // Decoded instruction class; K_ILL covers every undecodable pattern.
    typedef enum logic [2:0] {
        K_ILL,
        K_MOVI,
        K_MOVR,
        K_ADD,
        K_CMP,
        K_AND,
        K_MVN
    } kind_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 13;
    localparam int OP_HI  = 12;
    localparam int OP_LO  = 11;
    localparam int RN_HI  = 10;
    localparam int RN_LO  = 8;
    localparam int RD_HI  = 7;
    localparam int RD_LO  = 5;
    localparam int SH_HI  = 4;
    localparam int SH_LO  = 3;
    localparam int RM_HI  = 2;
    localparam int RM_LO  = 0;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    function automatic kind_t decode(input logic [15:0] ins);
        logic [2:0] opc;
        logic [1:0] op;
        kind_t      k;
        opc = ins[OPC_HI:OPC_LO];
        op  = ins[OP_HI:OP_LO];
        k   = K_ILL;
        if (opc == OPC_MOV) begin
            if (op == OP_MOVI)      k = K_MOVI;
            else if (op == OP_MOVR) k = K_MOVR;
        end else if (opc == OPC_ALU) begin
            case (op)
                OP_ADD:  k = K_ADD;
                OP_CMP:  k = K_CMP;
                OP_AND:  k = K_AND;
                default: k = K_MVN;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Instruction handshake and ALU drive/return bundle for exec_sequencer.
// slave is the sequencer side; master is the upstream issuer plus the ALU.
interface exec_sequencer_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] alu_ain;
    logic [15:0] alu_bin;
    logic [1:0]  alu_op;
    logic [15:0] alu_out;
    logic [2:0]  alu_status;

    modport master (
        output in_valid, instr, alu_out, alu_status,
        input  in_ready, alu_ain, alu_bin, alu_op
    );

    modport slave (
        input  in_valid, instr, alu_out, alu_status,
        output in_ready, alu_ain, alu_bin, alu_op
    );

endinterface

// File: rtl/exec_regfile.sv
// General register file for exec_sequencer: one synchronous write port,
// combinational operand and debug read ports, cleared by the asynchronous reset.
module exec_regfile #(
    parameter int NREG = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  waddr,
    input  logic [15:0]              wdata,
    input  logic [$clog2(NREG)-1:0]  raddr,
    output logic [15:0]              rdata,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [15:0]              dbg_data
);

    logic [15:0] regs [NREG];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata    = regs[raddr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle execute stage in front of an external ALU: decode, operand load, execute, write back.
// Build option: define STATUS_ALL_EN to load status_q on every ALU-class instruction, not just CMP.
module exec_sequencer
    import exec_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    exec_sequencer_if.slave   bus,
    output logic [2:0]        status_q,
    output logic [15:0]       c_q,
    output logic              done,
    output logic              illegal,
    input  logic [2:0]        dbg_addr,
    output logic [15:0]       dbg_data
);

    // Register fields are 3 bits wide, so the file must hold exactly eight entries.
    if (NREG != 8) begin : g_nreg_check
        $error("exec_sequencer: NREG must be 8");
    end

    state_t      state, state_nx;
    logic [15:0] ir;
    logic [15:0] a_q, b_q;
    kind_t       kind, kind_in;

    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh, op;
    logic [7:0]  imm8;

    logic        rf_we;
    logic [2:0]  rf_waddr, rf_raddr;
    logic [15:0] rf_wdata, rf_rdata;
    logic        status_ld;

    function automatic logic [15:0] shift1(input logic [15:0] v, input logic [1:0] code);
        case (code)
            SH_LSL:  return {v[14:0], 1'b0};
            SH_LSR:  return {1'b0, v[15:1]};
            SH_ASR:  return {v[15], v[15:1]};
            default: return v;
        endcase
    endfunction

    assign rn   = ir[RN_HI:RN_LO];
    assign rd   = ir[RD_HI:RD_LO];
    assign rm   = ir[RM_HI:RM_LO];
    assign sh   = ir[SH_HI:SH_LO];
    assign op   = ir[OP_HI:OP_LO];
    assign imm8 = ir[IMM_HI:IMM_LO];

    assign kind    = decode(ir);
    assign kind_in = decode(bus.instr);

`ifdef STATUS_ALL_EN
    assign status_ld = (kind inside {K_MOVR, K_ADD, K_CMP, K_AND, K_MVN});
`else
    assign status_ld = (kind == K_CMP);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    case (kind_in)
                        K_MOVI:                state_nx = S_WB_IMM;
                        K_MOVR, K_MVN:         state_nx = S_LOAD_B;
                        K_ADD, K_CMP, K_AND:   state_nx = S_LOAD_A;
                        default:               state_nx = S_FIN;
                    endcase
                end
            end
            S_LOAD_A: state_nx = S_LOAD_B;
            S_LOAD_B: state_nx = S_EXEC;
            S_EXEC:   state_nx = (kind == K_CMP) ? S_FIN : S_WB;
            S_WB:     state_nx = S_FIN;
            S_WB_IMM: state_nx = S_FIN;
            S_FIN:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // done/illegal are registered off the next state so they are high exactly while in FIN;
    // the only path into FIN straight from IDLE is an undecodable instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir       <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
            done     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            done    <= (state_nx == S_FIN);
            illegal <= (state == S_IDLE) && (state_nx == S_FIN);
            if (state == S_IDLE && bus.in_valid) ir <= bus.instr;
            if (state == S_LOAD_A) a_q <= rf_rdata;
            if (state == S_LOAD_B) b_q <= rf_rdata;
            if (state == S_EXEC) begin
                c_q <= bus.alu_out;
                if (status_ld) status_q <= bus.alu_status;
            end
        end
    end

    assign rf_raddr = (state == S_LOAD_A) ? rn : rm;
    assign rf_we    = (state == S_WB) || (state == S_WB_IMM);
    assign rf_waddr = (state == S_WB) ? rd : rn;
    assign rf_wdata = (state == S_WB) ? c_q : {{8{imm8[7]}}, imm8};

    exec_regfile #(.NREG(NREG)) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr    (rf_raddr),
        .rdata    (rf_rdata),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign bus.in_ready = (state == S_IDLE);
    assign bus.alu_bin  = shift1(b_q, sh);
    assign bus.alu_ain  = (kind == K_MOVR) ? 16'h0000 : a_q;
    assign bus.alu_op   = (kind == K_MOVR) ? 2'b00 : op;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a behavioural ALU alongside.
// Expected register, C and status values are hand-computed per instruction.
module tb_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  status_q;
    logic [15:0] c_q;
    logic        done;
    logic        illegal;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_r [8];
    logic [2:0]  exp_st;

    logic [15:0] alu_r;
    logic        alu_v;

    exec_sequencer_if bus ();

    exec_sequencer #(.NREG(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .status_q (status_q),
        .c_q      (c_q),
        .done     (done),
        .illegal  (illegal),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // ALU: 00 add, 01 subtract, 10 and, 11 not Bin; status {V,N,Z}
    always_comb begin
        alu_r = '0;
        alu_v = 1'b0;
        case (bus.alu_op)
            2'b00: begin
                alu_r = bus.alu_ain + bus.alu_bin;
                alu_v = (bus.alu_ain[15] == bus.alu_bin[15]) && (alu_r[15] != bus.alu_ain[15]);
            end
            2'b01: begin
                alu_r = bus.alu_ain - bus.alu_bin;
                alu_v = (bus.alu_ain[15] != bus.alu_bin[15]) && (alu_r[15] != bus.alu_ain[15]);
            end
            2'b10:   alu_r = bus.alu_ain & bus.alu_bin;
            default: alu_r = ~bus.alu_bin;
        endcase
        bus.alu_out    = alu_r;
        bus.alu_status = {alu_v, alu_r[15], (alu_r == 16'h0000)};
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check_eq($sformatf("%s R%0d", tag, i), dbg_data, exp_r[i]);
        end
    endtask

    task automatic issue(input string tag, input logic [15:0] ins, input int lat, input logic ill,
                         input int ecyc, input logic [1:0] eop, input logic [15:0] ebin,
                         input logic [15:0] ec, input bit hold);
        int          cyc;
        int          w;
        logic [1:0]  sop;
        logic [15:0] sbin;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq({tag, " accept_ready"}, 16'(bus.in_ready), 16'h0001);
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.in_valid = 1'b0;
        cyc  = 1;
        sop  = '0;
        sbin = '0;
        while (1) begin
            if (cyc == ecyc) begin
                sop  = bus.alu_op;
                sbin = bus.alu_bin;
            end
            check_eq({tag, " busy_ready"}, 16'(bus.in_ready), 16'h0000);
            if (done || cyc >= 10) break;
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, " done"}, 16'(done), 16'h0001);
        check_eq({tag, " latency"}, 16'(cyc), 16'(lat));
        check_eq({tag, " illegal"}, 16'(illegal), 16'(ill));
        if (ecyc != 0) begin
            check_eq({tag, " alu_op"}, 16'(sop), 16'(eop));
            check_eq({tag, " alu_bin"}, sbin, ebin);
        end
        check_eq({tag, " c_q"}, c_q, ec);
        check_eq({tag, " status"}, 16'(status_q), 16'(exp_st));
        check_regs(tag);
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.instr    = '0;
        dbg_addr     = '0;
        exp_st       = '0;
        for (int i = 0; i < 8; i++) exp_r[i] = '0;

        #12;
        check_eq("rst in_ready", 16'(bus.in_ready), 16'h0001);
        check_eq("rst done", 16'(done), 16'h0000);
        check_eq("rst illegal", 16'(illegal), 16'h0000);
        check_eq("rst c_q", c_q, 16'h0000);
        check_eq("rst status", 16'(status_q), 16'h0000);
        check_eq("rst ain", bus.alu_ain, 16'h0000);
        check_eq("rst bin", bus.alu_bin, 16'h0000);
        check_eq("rst op", 16'(bus.alu_op), 16'h0000);
        check_regs("rst");
        @(negedge clk);
        reset_n = 1'b1;

        exp_r[0] = 16'h0005;
        issue("movi_r0", 16'hD005, 2, 1'b0, 0, 2'b00, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        check_eq("done_pulse", 16'(done), 16'h0000);
        check_eq("idle_ready", 16'(bus.in_ready), 16'h0001);

        exp_r[4] = 16'hFF80;
        issue("movi_r4", 16'hD480, 2, 1'b0, 0, 2'b00, 16'h0000, 16'h0000, 1'b0);
        exp_r[1] = 16'h0003;
        issue("movi_r1", 16'hD103, 2, 1'b0, 0, 2'b00, 16'h0000, 16'h0000, 1'b0);

        exp_r[2] = 16'h0008;
`ifdef STATUS_ALL_EN
        exp_st = 3'b000;
`endif
        issue("add", 16'hA041, 5, 1'b0, 3, 2'b00, 16'h0003, 16'h0008, 1'b0);

        exp_st = 3'b001;
        issue("cmp_eq", 16'hA800, 4, 1'b0, 3, 2'b01, 16'h0005, 16'h0000, 1'b0);
        exp_st = 3'b010;
        issue("cmp_neg", 16'hA900, 4, 1'b0, 3, 2'b01, 16'h0005, 16'hFFFE, 1'b0);

        exp_r[5] = 16'hFFC0;
`ifdef STATUS_ALL_EN
        exp_st = 3'b010;
`endif
        issue("mov_asr", 16'hC0BC, 4, 1'b0, 2, 2'b00, 16'hFFC0, 16'hFFC0, 1'b0);
        exp_r[5] = 16'h7FC0;
`ifdef STATUS_ALL_EN
        exp_st = 3'b000;
`endif
        issue("mov_lsr", 16'hC0B4, 4, 1'b0, 2, 2'b00, 16'h7FC0, 16'h7FC0, 1'b0);

        exp_r[6] = 16'hFFFC;
`ifdef STATUS_ALL_EN
        exp_st = 3'b010;
`endif
        issue("mvn", 16'hB8C1, 4, 1'b0, 2, 2'b11, 16'h0003, 16'hFFFC, 1'b0);
        exp_r[7] = 16'h7F80;
`ifdef STATUS_ALL_EN
        exp_st = 3'b000;
`endif
        issue("and", 16'hB4E5, 5, 1'b0, 3, 2'b10, 16'h7FC0, 16'h7F80, 1'b0);

        issue("ill_zero", 16'h0000, 1, 1'b1, 0, 2'b00, 16'h0000, 16'h7F80, 1'b0);
        issue("ill_mov01", 16'hC800, 1, 1'b1, 0, 2'b00, 16'h0000, 16'h7F80, 1'b0);

        exp_r[3] = 16'h007F;
        issue("b2b_first", 16'hD37F, 2, 1'b0, 0, 2'b00, 16'h0000, 16'h7F80, 1'b1);
        exp_r[7] = 16'hFFFF;
        issue("b2b_second", 16'hD7FF, 2, 1'b0, 0, 2'b00, 16'h0000, 16'h7F80, 1'b1);
        bus.in_valid = 1'b0;

        // Abort an ADD while it sits in LOAD_B
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.instr    = 16'hA041;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst in_ready", 16'(bus.in_ready), 16'h0001);
        check_eq("arst done", 16'(done), 16'h0000);
        check_eq("arst status", 16'(status_q), 16'h0000);
        check_eq("arst c_q", c_q, 16'h0000);
        check_eq("arst ain", bus.alu_ain, 16'h0000);
        check_eq("arst bin", bus.alu_bin, 16'h0000);
        for (int i = 0; i < 8; i++) exp_r[i] = '0;
        exp_st = '0;
        check_regs("arst");
        @(negedge clk);
        reset_n = 1'b1;

        exp_r[0] = 16'h0005;
        issue("post_rst", 16'hD005, 2, 1'b0, 0, 2'b00, 16'h0000, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle execute stage sitting directly upstream of the ALU.
- Accepts one 16-bit instruction per valid/ready handshake, decodes it, and reads the 8x16 register file into operand registers A and B.
- Drives ALU Ain/Bin/ALUop, captures the ALU result into C and the ALU status into a status register, and writes C back.
- The ALU is instantiated alongside this block, not inside it.

Parameters:
- NREG, 8, number of general registers; must equal 2^3 to match the 3-bit register fields.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  high only in IDLE.
- instr  in  16  fields: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm, [7:0] imm8.
- alu_ain  out  16  to ALU Ain.
- alu_bin  out  16  to ALU Bin.
- alu_op  out  2  to ALU ALUop.
- alu_out  in  16  from ALU.
- alu_status  in  3  from ALU: [0]=Z, [1]=N, [2]=V.
- status_q  out  3  registered Z/N/V.
- c_q  out  16  result register C.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle pulse, coincident with done, for an undecodable instruction.
- dbg_addr  in  3  debug read address.
- dbg_data  out  16  combinational read of R[dbg_addr].

Behaviour:
- Reset (asynchronous, any state) drives:
  - state to IDLE;
  - all registers R0–R7, A, B and C to 0;
  - status_q to 0;
  - the latched instruction to 0;
  - done and illegal to 0;
  - so alu_ain=0, alu_bin=0, alu_op=00 out of reset.
- Handshake:
  - Transfer occurs on a clk edge with in_valid=1 and in_ready=1; the instruction is latched on that edge (edge 0).
  - in_valid is ignored outside IDLE; no queuing.
- Decode:
  - 110/10 MOV Rn,#sext(imm8)
  - 110/00 MOV Rd,Rm{sh}
  - 101/00 ADD Rd,Rn,Rm{sh}
  - 101/01 CMP Rn,Rm{sh}
  - 101/10 AND Rd,Rn,Rm{sh}
  - 101/11 MVN Rd,Rm{sh}
  - Everything else is illegal.
- States: IDLE, LOAD_A, LOAD_B, EXEC, WB, WB_IMM, FIN.
- Transitions from IDLE on accept:
  - MOV imm → WB_IMM.
  - MOV reg / MVN → LOAD_B.
  - ADD / CMP / AND → LOAD_A.
  - illegal → FIN.
- Other transitions:
  - LOAD_A: A<=R[Rn]; → LOAD_B.
  - LOAD_B: B<=R[Rm]; → EXEC.
  - EXEC: C<=alu_out; status_q<=alu_status for CMP only; CMP → FIN, otherwise → WB.
  - WB: R[Rd]<=C; → FIN.
  - WB_IMM: R[Rn]<={{8{imm8[7]}},imm8}; C unchanged; → FIN.
  - FIN: done=1 (illegal=1 if illegal); → IDLE.
- done latency, counted from edge 0:
  - illegal: 1 edge
  - MOV imm: 2 edges
  - MOV reg / MVN / CMP: 4 edges
  - ADD / AND: 5 edges
- ALU drive, combinational from latched state:
  - alu_bin = shift(B).
  - alu_ain = 0 for MOV reg, otherwise A.
  - alu_op = 00 for MOV reg, otherwise op.
  - Only sampled in EXEC.
- Shift (16-bit, 1 position):
  - 00 none
  - 01 LSL, LSB=0
  - 10 LSR, MSB=0
  - 11 ASR, MSB kept
- Rd equal to Rn or Rm is legal; operands are already latched, so there is no hazard.
- An illegal instruction modifies no register and no status.

Optional Feature:
- Macro STATUS_ALL_EN.
- Defined: status_q loads in EXEC for every ALU-class instruction (MOV reg, ADD, CMP, AND, MVN).
- Undefined: only CMP loads status_q.
- Latency and register writes are identical in both builds.

Decomposition:
- Package exec_pkg:
  - state enum;
  - opcode constants OPC_MOV=3'b110, OPC_ALU=3'b101;
  - op constants;
  - shift codes SH_NONE/SH_LSL/SH_LSR/SH_ASR;
  - instruction field bit positions.
- Sub-module exec_regfile: 8x16, one synchronous write port, two combinational read ports (operand read and dbg), cleared on reset.
- The shifter is an inline function.

Test Plan:
- Reset, then 0xD005 (MOV R0,#5) → done 2 edges after accept, dbg R0=0x0005; then 0xD480 (MOV R4,#0x80) → R4=0xFF80.
- 0xD103 (MOV R1,#3), then 0xA041 (ADD R2,R0,R1) → alu_op=00 in EXEC, done at edge 5, R2=0x0008, C=0x0008, status_q unchanged.
- 0xA800 (CMP R0,R0) → status_q=3'b001, done at edge 4, no register changes; 0xA900 (CMP R1,R0) → status_q=3'b010.
- 0xC0BC (MOV R5,R4,ASR) → R5=0xFFC0; 0xC0B4 (LSR) → R5=0x7FC0. Without STATUS_ALL_EN, status_q keeps 3'b010; with it, status_q=3'b000 after the LSR.
- 0x0000 (illegal) → done=1 and illegal=1 at edge 1, all registers unchanged. in_valid held high across back-to-back instructions → in_ready low from accept until done.
- Drive reset_n low during LOAD_B of an ADD → state IDLE and in_ready=1 immediately, done=0, all dbg reads 0, status_q=0.
